// File: rtl/ariane_axi_pkg.sv
// AXI4 channel and bundle types shared by the cache-side masters and the merged slave port.
// Master side carries a 4-bit ID; slave side carries a 5-bit ID whose MSB names the source master.
// Helper functions widen request channels (prepend source bit) and narrow response channels.
package ariane_axi;

    localparam int unsigned IdWidth      = 4;
    localparam int unsigned IdWidthSlave = 5;
    localparam int unsigned AddrWidth    = 64;
    localparam int unsigned DataWidth    = 64;
    localparam int unsigned StrbWidth    = DataWidth / 8;
    localparam int unsigned UserWidth    = 1;

    // Slave-side ID bit that identifies which master issued the transaction.
    localparam int unsigned ArbSrcBit    = IdWidthSlave - 1;

    typedef logic [IdWidth-1:0]      id_t;
    typedef logic [IdWidthSlave-1:0] id_slv_t;
    typedef logic [AddrWidth-1:0]    addr_t;
    typedef logic [DataWidth-1:0]    data_t;
    typedef logic [StrbWidth-1:0]    strb_t;
    typedef logic [UserWidth-1:0]    user_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [5:0] atop;
        user_t      user;
    } aw_chan_t;

    typedef struct packed {
        id_slv_t    id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [5:0] atop;
        user_t      user;
    } aw_chan_slv_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_slv_t    id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_slv_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        user_t      user;
    } ar_chan_t;

    typedef struct packed {
        id_slv_t    id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        user_t      user;
    } ar_chan_slv_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        id_slv_t    id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_slv_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

    typedef struct packed {
        aw_chan_slv_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        ar_chan_slv_t ar;
        logic         ar_valid;
        logic         r_ready;
    } req_slv_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        b_chan_slv_t b;
        logic        r_valid;
        r_chan_slv_t r;
    } resp_slv_t;

    function automatic aw_chan_slv_t aw_widen(input aw_chan_t aw, input logic src);
        aw_chan_slv_t o;
        o.id    = {src, aw.id};
        o.addr  = aw.addr;
        o.len   = aw.len;
        o.size  = aw.size;
        o.burst = aw.burst;
        o.lock  = aw.lock;
        o.cache = aw.cache;
        o.prot  = aw.prot;
        o.qos   = aw.qos;
        o.atop  = aw.atop;
        o.user  = aw.user;
        return o;
    endfunction

    function automatic ar_chan_slv_t ar_widen(input ar_chan_t ar, input logic src);
        ar_chan_slv_t o;
        o.id    = {src, ar.id};
        o.addr  = ar.addr;
        o.len   = ar.len;
        o.size  = ar.size;
        o.burst = ar.burst;
        o.lock  = ar.lock;
        o.cache = ar.cache;
        o.prot  = ar.prot;
        o.qos   = ar.qos;
        o.user  = ar.user;
        return o;
    endfunction

    function automatic b_chan_t b_narrow(input b_chan_slv_t b);
        b_chan_t o;
        o.id   = b.id[IdWidth-1:0];
        o.resp = b.resp;
        o.user = b.user;
        return o;
    endfunction

    function automatic r_chan_t r_narrow(input r_chan_slv_t r);
        r_chan_t o;
        o.id   = r.id[IdWidth-1:0];
        o.data = r.data;
        o.resp = r.resp;
        o.last = r.last;
        o.user = r.user;
        return o;
    endfunction

endpackage

// File: rtl/axi_rr_lock_arb.sv
// Two-input round-robin arbiter with a valid-lock, used for the AW and AR address channels.
// Latency: combinational grant; pointer and lock update on the clock edge.
// Backpressure: en_i low masks the grant (valid_o and both ready_o low); a stalled winner is held.
// Ports: req_i = per-master valid, ready_i = downstream ready, valid_o/src_o = merged valid and
// winning source, ready_o = per-master ready (only the winner sees ready_i).
module axi_rr_lock_arb (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic       src_o,
    output logic [1:0] ready_o
);

    logic ptr_q;
    logic lock_q;
    logic lock_src_q;
    logic sel;
    logic gate;

    // A presented-but-not-accepted request keeps its grant so the downstream valid/payload stay
    // stable until the handshake, even if the other master is now favoured by the pointer.
    always_comb begin
        if (lock_q) begin
            sel = lock_src_q;
        end else if (req_i == 2'b11) begin
            sel = ptr_q;
        end else begin
            sel = req_i[1];
        end
    end

    assign gate       = rst_ni & en_i;
    assign src_o      = sel;
    assign valid_o    = gate & req_i[sel];
    assign ready_o[0] = gate & ~sel & ready_i;
    assign ready_o[1] = gate & sel & ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= 1'b0;
            lock_q     <= 1'b0;
            lock_src_q <= 1'b0;
        end else if (valid_o && ready_i) begin
            lock_q <= 1'b0;
            ptr_q  <= ~sel;
        end else if (valid_o) begin
            lock_q     <= 1'b1;
            lock_src_q <= sel;
        end
    end

endmodule

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO, registered storage, no fall-through.
// Latency: a pushed entry is visible at data_o one cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; push+pop together keeps count.
// Ports: clk_i/rst_ni (async active-low), full_o/empty_o status, data_i/push_i write, data_o/pop_i read.
// DEPTH must be a power of two so the pointers wrap naturally.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(DEPTH);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [AddrW-1:0]                 rd_ptr_q;
    logic [AddrW-1:0]                 wr_ptr_q;
    logic [AddrW:0]                   cnt_q;
    logic                             push_en;
    logic                             pop_en;

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AddrW'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + AddrW'(1);
            end
            if (push_en && !pop_en) begin
                cnt_q <= cnt_q + (AddrW + 1)'(1);
            end else if (pop_en && !push_en) begin
                cnt_q <= cnt_q - (AddrW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/axi_rr_arbiter_2to1.sv
// Round-robin 2:1 AXI4 arbiter merging two 4-bit-ID masters onto one 5-bit-ID slave port.
// Latency: AW/AR/B/R combinational; first W beat one cycle after its AW handshake at the earliest.
// Backpressure: AW stalls while the W route FIFO is full; W held off until its AW is granted.
// Ports: clk_i, rst_ni (async active-low); m0/m1_req_i + m0/m1_resp_o master side; slv_req_o +
// slv_resp_i slave side; m0/m1_stall_o stall counters only when AXI_ARB_STALL_CNT_EN is defined.
// The slave-side ID MSB carries the source master, so B/R route back without any tracking.
module axi_rr_arbiter_2to1
    import ariane_axi::*;
#(
    parameter int unsigned WFifoDepth = 4,
    parameter int unsigned StallCntW  = 32
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  req_t      m0_req_i,
    output resp_t     m0_resp_o,
    input  req_t      m1_req_i,
    output resp_t     m1_resp_o,
    output req_slv_t  slv_req_o,
    input  resp_slv_t slv_resp_i
`ifdef AXI_ARB_STALL_CNT_EN
    ,
    output logic [StallCntW-1:0] m0_stall_o,
    output logic [StallCntW-1:0] m1_stall_o
`endif
);

    logic       aw_vld;
    logic       aw_src;
    logic [1:0] aw_rdy;
    logic       aw_hs;
    logic       ar_vld;
    logic       ar_src;
    logic [1:0] ar_rdy;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_src;
    logic       w_fifo_pop;
    logic       w_route_vld;

    axi_rr_lock_arb u_aw_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   ({m1_req_i.aw_valid, m0_req_i.aw_valid}),
        .en_i    (~w_fifo_full),
        .ready_i (slv_resp_i.aw_ready),
        .valid_o (aw_vld),
        .src_o   (aw_src),
        .ready_o (aw_rdy)
    );

    axi_rr_lock_arb u_ar_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   ({m1_req_i.ar_valid, m0_req_i.ar_valid}),
        .en_i    (1'b1),
        .ready_i (slv_resp_i.ar_ready),
        .valid_o (ar_vld),
        .src_o   (ar_src),
        .ready_o (ar_rdy)
    );

    assign aw_hs = aw_vld & slv_resp_i.aw_ready;

    // One entry per granted AW, holding its source; the head steers W until that burst's last beat.
    fifo_v3 #(
        .DATA_WIDTH (1),
        .DEPTH      (WFifoDepth)
    ) u_w_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .data_i  (aw_src),
        .push_i  (aw_hs),
        .data_o  (w_src),
        .pop_i   (w_fifo_pop)
    );

    assign w_route_vld = rst_ni & ~w_fifo_empty;
    assign w_fifo_pop  = slv_req_o.w_valid & slv_resp_i.w_ready & slv_req_o.w.last;

    always_comb begin
        slv_req_o = '0;
        m0_resp_o = '0;
        m1_resp_o = '0;

        slv_req_o.aw       = aw_widen(aw_src ? m1_req_i.aw : m0_req_i.aw, aw_src);
        slv_req_o.aw_valid = aw_vld;
        m0_resp_o.aw_ready = aw_rdy[0];
        m1_resp_o.aw_ready = aw_rdy[1];

        slv_req_o.ar       = ar_widen(ar_src ? m1_req_i.ar : m0_req_i.ar, ar_src);
        slv_req_o.ar_valid = ar_vld;
        m0_resp_o.ar_ready = ar_rdy[0];
        m1_resp_o.ar_ready = ar_rdy[1];

        slv_req_o.w        = w_src ? m1_req_i.w : m0_req_i.w;
        slv_req_o.w_valid  = w_route_vld & (w_src ? m1_req_i.w_valid : m0_req_i.w_valid);
        m0_resp_o.w_ready  = w_route_vld & ~w_src & slv_resp_i.w_ready;
        m1_resp_o.w_ready  = w_route_vld & w_src & slv_resp_i.w_ready;

        m0_resp_o.b        = b_narrow(slv_resp_i.b);
        m1_resp_o.b        = b_narrow(slv_resp_i.b);
        m0_resp_o.b_valid  = rst_ni & slv_resp_i.b_valid & ~slv_resp_i.b.id[ArbSrcBit];
        m1_resp_o.b_valid  = rst_ni & slv_resp_i.b_valid & slv_resp_i.b.id[ArbSrcBit];
        slv_req_o.b_ready  = rst_ni & (slv_resp_i.b.id[ArbSrcBit] ? m1_req_i.b_ready
                                                                  : m0_req_i.b_ready);

        m0_resp_o.r        = r_narrow(slv_resp_i.r);
        m1_resp_o.r        = r_narrow(slv_resp_i.r);
        m0_resp_o.r_valid  = rst_ni & slv_resp_i.r_valid & ~slv_resp_i.r.id[ArbSrcBit];
        m1_resp_o.r_valid  = rst_ni & slv_resp_i.r_valid & slv_resp_i.r.id[ArbSrcBit];
        slv_req_o.r_ready  = rst_ni & (slv_resp_i.r.id[ArbSrcBit] ? m1_req_i.r_ready
                                                                  : m0_req_i.r_ready);
    end

`ifdef AXI_ARB_STALL_CNT_EN
    logic [1:0]                stall;
    logic [1:0][StallCntW-1:0] stall_cnt_q;

    // A master is stalled in a cycle when it presents AW or AR and that channel is not accepted.
    assign stall[0] = (m0_req_i.aw_valid & ~aw_rdy[0]) | (m0_req_i.ar_valid & ~ar_rdy[0]);
    assign stall[1] = (m1_req_i.aw_valid & ~aw_rdy[1]) | (m1_req_i.ar_valid & ~ar_rdy[1]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (stall[i] && (stall_cnt_q[i] != '1)) begin
                    stall_cnt_q[i] <= stall_cnt_q[i] + StallCntW'(1);
                end
            end
        end
    end

    assign m0_stall_o = stall_cnt_q[0];
    assign m1_stall_o = stall_cnt_q[1];
`endif

endmodule

// File: tb/tb_axi_rr_arbiter_2to1.sv
// Directed bench for axi_rr_arbiter_2to1: reset outputs, AW RR and lock, W FIFO full stall,
// W held before AW, table-driven B/R return routing, AR lock (and stall counters when enabled).
module tb_axi_rr_arbiter_2to1;
    import ariane_axi::*;

    logic      clk;
    logic      rst_ni;
    req_t      m0_req;
    req_t      m1_req;
    resp_t     m0_resp;
    resp_t     m1_resp;
    req_slv_t  slv_req;
    resp_slv_t slv_resp;
`ifdef AXI_ARB_STALL_CNT_EN
    logic [31:0] m0_stall;
    logic [31:0] m1_stall;
`endif

    int n_cmp;
    int n_err;

    axi_rr_arbiter_2to1 #(
        .WFifoDepth (4),
        .StallCntW  (32)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .m0_req_i   (m0_req),
        .m0_resp_o  (m0_resp),
        .m1_req_i   (m1_req),
        .m1_resp_o  (m1_resp),
        .slv_req_o  (slv_req),
        .slv_resp_i (slv_resp)
`ifdef AXI_ARB_STALL_CNT_EN
        ,
        .m0_stall_o (m0_stall),
        .m1_stall_o (m1_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       bv;
        logic [4:0] bid;
        logic       rv;
        logic [4:0] rid;
        logic [3:0] rdy;     // {m1 r_ready, m0 r_ready, m1 b_ready, m0 b_ready}
        logic       e_m0_bv;
        logic       e_m1_bv;
        logic       e_m0_rv;
        logic       e_m1_rv;
        logic [3:0] e_bid;
        logic [3:0] e_rid;
        logic       e_brdy;
        logic       e_rrdy;
    } ret_vec_t;

    ret_vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        m0_req   = '0;
        m1_req   = '0;
        slv_resp = '0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset just released (cycle 0).
    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        rst_ni = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_ni = 1'b0;
        clear_inputs();

        vecs[0] = '{1'b1, 5'h02, 1'b1, 5'h1A, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2, 4'hA, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 5'h12, 1'b0, 5'h05, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h5, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 5'h1F, 1'b1, 5'h0C, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'hC, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 5'h07, 1'b1, 5'h13, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7, 4'h3, 1'b0, 1'b1};

        cyc();
        cyc();

        // ---- Reset: outputs quiet even with every input active ----
        m0_req.aw_valid = 1'b1; m0_req.aw.id = 4'h3;
        m1_req.aw_valid = 1'b1; m1_req.aw.id = 4'h3;
        m1_req.ar_valid = 1'b1;
        m0_req.w_valid  = 1'b1; m0_req.w.last = 1'b1;
        m0_req.b_ready  = 1'b1; m1_req.b_ready = 1'b1;
        m0_req.r_ready  = 1'b1; m1_req.r_ready = 1'b1;
        slv_resp.aw_ready = 1'b1; slv_resp.ar_ready = 1'b1; slv_resp.w_ready = 1'b1;
        slv_resp.b_valid  = 1'b1; slv_resp.b.id = 5'h00;
        slv_resp.r_valid  = 1'b1; slv_resp.r.id = 5'h10;
        settle();
        chk("rst_slv_aw_valid", slv_req.aw_valid, 0);
        chk("rst_slv_ar_valid", slv_req.ar_valid, 0);
        chk("rst_slv_w_valid", slv_req.w_valid, 0);
        chk("rst_m0_b_valid", m0_resp.b_valid, 0);
        chk("rst_m1_r_valid", m1_resp.r_valid, 0);
        chk("rst_m0_aw_ready", m0_resp.aw_ready, 0);
        chk("rst_m1_ar_ready", m1_resp.ar_ready, 0);
        chk("rst_m0_w_ready", m0_resp.w_ready, 0);
        chk("rst_slv_b_ready", slv_req.b_ready, 0);
        chk("rst_slv_r_ready", slv_req.r_ready, 0);
`ifdef AXI_ARB_STALL_CNT_EN
        chk("rst_m0_stall", m0_stall, 0);
        chk("rst_m1_stall", m1_stall, 0);
`endif

        // ---- 1: both AWs pending at reset exit; m0 first, then m1; W order 0,1 ----
        cyc();
        m1_req.ar_valid = 1'b0; m0_req.w_valid = 1'b0;
        slv_resp.b_valid = 1'b0; slv_resp.r_valid = 1'b0;
        rst_ni = 1'b1;
        settle();
        chk("t1_c0_aw_valid", slv_req.aw_valid, 1);
        chk("t1_c0_aw_id", slv_req.aw.id, 5'h03);
        chk("t1_c0_m0_aw_ready", m0_resp.aw_ready, 1);
        chk("t1_c0_m1_aw_ready", m1_resp.aw_ready, 0);
        cyc();
        m0_req.aw_valid = 1'b0;
        settle();
        chk("t1_c1_aw_id", slv_req.aw.id, 5'h13);
        chk("t1_c1_m1_aw_ready", m1_resp.aw_ready, 1);
        chk("t1_c1_m0_aw_ready", m0_resp.aw_ready, 0);
        cyc();
        m1_req.aw_valid = 1'b0;
        m0_req.w_valid = 1'b1; m0_req.w.data = 64'hA0; m0_req.w.last = 1'b1;
        m1_req.w_valid = 1'b1; m1_req.w.data = 64'hB1; m1_req.w.last = 1'b1;
        settle();
        chk("t1_w0_valid", slv_req.w_valid, 1);
        chk("t1_w0_data", slv_req.w.data, 64'hA0);
        chk("t1_w0_m0_ready", m0_resp.w_ready, 1);
        chk("t1_w0_m1_ready", m1_resp.w_ready, 0);
        cyc();
        m0_req.w_valid = 1'b0;
        settle();
        chk("t1_w1_data", slv_req.w.data, 64'hB1);
        chk("t1_w1_m1_ready", m1_resp.w_ready, 1);
        chk("t1_w1_m0_ready", m0_resp.w_ready, 0);
        cyc();
        settle();
        chk("t1_fifo_empty_w_valid", slv_req.w_valid, 0);
        chk("t1_fifo_empty_m1_ready", m1_resp.w_ready, 0);

        // ---- 2: m0 AW locked for 3 stalled cycles; m1 cannot preempt ----
        do_reset();
        m0_req.aw_valid = 1'b1; m0_req.aw.id = 4'h5; m0_req.aw.addr = 64'h1000;
        slv_resp.aw_ready = 1'b0;
        settle();
        chk("t2_c0_addr", slv_req.aw.addr, 64'h1000);
        chk("t2_c0_id", slv_req.aw.id, 5'h05);
        chk("t2_c0_m0_aw_ready", m0_resp.aw_ready, 0);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            if (c == 1) begin
                m1_req.aw_valid = 1'b1; m1_req.aw.id = 4'h6; m1_req.aw.addr = 64'h2000;
            end
            if (c == 3) slv_resp.aw_ready = 1'b1;
            settle();
            chk("t2_lock_addr", slv_req.aw.addr, 64'h1000);
            chk("t2_lock_id", slv_req.aw.id, 5'h05);
            chk("t2_lock_valid", slv_req.aw_valid, 1);
            chk("t2_lock_m1_aw_ready", m1_resp.aw_ready, 0);
            if (c == 3) chk("t2_hs_m0_aw_ready", m0_resp.aw_ready, 1);
        end
        cyc();
        m0_req.aw_valid = 1'b0;
        settle();
        chk("t2_m1_addr", slv_req.aw.addr, 64'h2000);
        chk("t2_m1_id", slv_req.aw.id, 5'h16);
        chk("t2_m1_aw_ready", m1_resp.aw_ready, 1);

        // ---- 3: four m1 AWs fill the W FIFO; 5th stalls until one burst ends ----
        do_reset();
        m1_req.aw_valid = 1'b1; m1_req.aw.id = 4'h1;
        slv_resp.aw_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            m1_req.aw.addr = 64'(i * 16);
            settle();
            chk("t3_fill_m1_aw_ready", m1_resp.aw_ready, 1);
        end
        cyc();
        m1_req.aw.addr = 64'h40;
        m1_req.w_valid = 1'b1; m1_req.w.last = 1'b1;
        settle();
        chk("t3_full_aw_valid", slv_req.aw_valid, 0);
        chk("t3_full_m1_aw_ready", m1_resp.aw_ready, 0);
        chk("t3_full_m0_aw_ready", m0_resp.aw_ready, 0);
        chk("t3_full_w_valid", slv_req.w_valid, 1);
        cyc();
        slv_resp.w_ready = 1'b1;
        settle();
        chk("t3_pop_aw_valid", slv_req.aw_valid, 0);
        chk("t3_pop_m1_w_ready", m1_resp.w_ready, 1);
        cyc();
        slv_resp.w_ready = 1'b0;
        settle();
        chk("t3_freed_aw_valid", slv_req.aw_valid, 1);
        chk("t3_freed_m1_aw_ready", m1_resp.aw_ready, 1);
        chk("t3_freed_addr", slv_req.aw.addr, 64'h40);

        // ---- 4: m1 W held until after its AW; 4-beat burst with m0 blocked ----
        do_reset();
        m1_req.w_valid = 1'b1; m1_req.w.data = 64'hD0; m1_req.w.last = 1'b0;
        m0_req.w_valid = 1'b1; m0_req.w.data = 64'hEE; m0_req.w.last = 1'b1;
        slv_resp.w_ready = 1'b1;
        settle();
        chk("t4_early_w_valid", slv_req.w_valid, 0);
        chk("t4_early_m1_w_ready", m1_resp.w_ready, 0);
        chk("t4_early_m0_w_ready", m0_resp.w_ready, 0);
        cyc();
        m1_req.aw_valid = 1'b1; m1_req.aw.id = 4'h2;
        slv_resp.aw_ready = 1'b1;
        settle();
        chk("t4_aw_m1_aw_ready", m1_resp.aw_ready, 1);
        chk("t4_aw_m1_w_ready", m1_resp.w_ready, 0);
        chk("t4_aw_w_valid", slv_req.w_valid, 0);
        for (int b = 0; b < 4; b++) begin
            cyc();
            if (b == 0) m1_req.aw_valid = 1'b0;
            m1_req.w.data = 64'hD0 + 64'(b);
            m1_req.w.last = (b == 3);
            settle();
            chk("t4_beat_w_valid", slv_req.w_valid, 1);
            chk("t4_beat_data", slv_req.w.data, 64'hD0 + 64'(b));
            chk("t4_beat_m1_w_ready", m1_resp.w_ready, 1);
            chk("t4_beat_m0_w_ready", m0_resp.w_ready, 0);
        end
        cyc();
        m1_req.w_valid = 1'b0;
        settle();
        chk("t4_done_w_valid", slv_req.w_valid, 0);
        chk("t4_done_m0_w_ready", m0_resp.w_ready, 0);

        // ---- 5: B/R return routing (table) ----
        cyc();
        clear_inputs();
        slv_resp.r.data = 64'hCAFE;
        for (int v = 0; v < 4; v++) begin
            slv_resp.b_valid = vecs[v].bv;
            slv_resp.b.id    = vecs[v].bid;
            slv_resp.r_valid = vecs[v].rv;
            slv_resp.r.id    = vecs[v].rid;
            m0_req.b_ready   = vecs[v].rdy[0];
            m1_req.b_ready   = vecs[v].rdy[1];
            m0_req.r_ready   = vecs[v].rdy[2];
            m1_req.r_ready   = vecs[v].rdy[3];
            settle();
            chk($sformatf("t5_v%0d_m0_b_valid", v), m0_resp.b_valid, vecs[v].e_m0_bv);
            chk($sformatf("t5_v%0d_m1_b_valid", v), m1_resp.b_valid, vecs[v].e_m1_bv);
            chk($sformatf("t5_v%0d_m0_r_valid", v), m0_resp.r_valid, vecs[v].e_m0_rv);
            chk($sformatf("t5_v%0d_m1_r_valid", v), m1_resp.r_valid, vecs[v].e_m1_rv);
            chk($sformatf("t5_v%0d_b_id", v),
                vecs[v].bid[4] ? m1_resp.b.id : m0_resp.b.id, vecs[v].e_bid);
            chk($sformatf("t5_v%0d_r_id", v),
                vecs[v].rid[4] ? m1_resp.r.id : m0_resp.r.id, vecs[v].e_rid);
            chk($sformatf("t5_v%0d_slv_b_ready", v), slv_req.b_ready, vecs[v].e_brdy);
            chk($sformatf("t5_v%0d_slv_r_ready", v), slv_req.r_ready, vecs[v].e_rrdy);
            chk($sformatf("t5_v%0d_r_data", v),
                vecs[v].rid[4] ? m1_resp.r.data : m0_resp.r.data, 64'hCAFE);
            cyc();
        end

        // ---- 6: AR lock; m1 waits 7 cycles behind m0 ----
        do_reset();
        m0_req.ar_valid = 1'b1; m0_req.ar.id = 4'h4; m0_req.ar.addr = 64'h3000;
        m1_req.ar_valid = 1'b1; m1_req.ar.id = 4'h9; m1_req.ar.addr = 64'h4000;
        slv_resp.ar_ready = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) cyc();
            if (c == 6) slv_resp.ar_ready = 1'b1;
            settle();
            chk("t6_lock_addr", slv_req.ar.addr, 64'h3000);
            chk("t6_lock_id", slv_req.ar.id, 5'h04);
            chk("t6_lock_m1_ar_ready", m1_resp.ar_ready, 0);
        end
        chk("t6_hs_m0_ar_ready", m0_resp.ar_ready, 1);
        cyc();
        m0_req.ar_valid = 1'b0;
        settle();
        chk("t6_m1_id", slv_req.ar.id, 5'h19);
        chk("t6_m1_addr", slv_req.ar.addr, 64'h4000);
        chk("t6_m1_ar_ready", m1_resp.ar_ready, 1);
        cyc();
        m1_req.ar_valid = 1'b0;
        slv_resp.ar_ready = 1'b0;
        settle();
        chk("t6_idle_ar_valid", slv_req.ar_valid, 0);
`ifdef AXI_ARB_STALL_CNT_EN
        chk("t6_m1_stall", m1_stall, 7);
        chk("t6_m0_stall", m0_stall, 6);
        cyc();
        settle();
        chk("t6_m1_stall_hold", m1_stall, 7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
